// File: rtl/damage_accumulator.sv
// Per-frame damage accumulator: per-slot and tower saturating sums are latched on tick and presented for one cycle.
// Optional statistics counters (frame_count, missed_ticks) are enabled by defining DMG_STATS_EN.
//
// state | meaning
// ACCUM | accepting damage requests, waiting for tick
// APPLY | latched frame on outputs, applied_valid strobe, requests stalled
module damage_accumulator #(
   parameter int NUM_TARGETS = 16,
   parameter int SEL_W       = 5,
   parameter int IN_W        = 12,
   parameter int DMG_W       = 8
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SEL_W-1:0]             in_sel,
   input  logic [IN_W-1:0]              in_dmg,
   input  logic                         tick,
   output logic [NUM_TARGETS*DMG_W-1:0] applied_dmg,
   output logic [DMG_W-1:0]             tower_dmg,
   output logic                         applied_valid,
   output logic [15:0]                  frame_count,
   output logic [7:0]                   missed_ticks
);

   localparam int ACC_W = NUM_TARGETS * DMG_W;
   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_APPLY = 1'b1;
   localparam logic [DMG_W-1:0] DMG_MAX = '1;

   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [DMG_W-1:0] tower_acc_q, tower_acc_d;
   logic [ACC_W-1:0] out_q, out_d;
   logic [DMG_W-1:0] tower_out_q, tower_out_d;

   logic             accept;
   logic [DMG_W-1:0] dmg_clamped;
   logic [ACC_W-1:0] acc_n;
   logic [DMG_W-1:0] tower_n;

   function automatic logic [DMG_W-1:0] sat_add(input logic [DMG_W-1:0] a, input logic [DMG_W-1:0] b);
      logic [DMG_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DMG_W] ? DMG_MAX : s[DMG_W-1:0];
   endfunction

   always_comb begin
      accept      = in_valid && (state_q == ST_ACCUM);
      dmg_clamped = (in_dmg > IN_W'(DMG_MAX)) ? DMG_MAX : in_dmg[DMG_W-1:0];

      // acc_n/tower_n include this cycle's request so a same-cycle tick sees it
      acc_n   = acc_q;
      tower_n = tower_acc_q;
      if (accept) begin
         if (in_sel >= SEL_W'(NUM_TARGETS)) begin
            tower_n = sat_add(tower_acc_q, dmg_clamped);
         end else begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
               if (in_sel == SEL_W'(k)) begin
                  acc_n[k*DMG_W +: DMG_W] = sat_add(acc_q[k*DMG_W +: DMG_W], dmg_clamped);
               end
            end
         end
      end

      state_d     = state_q;
      acc_d       = acc_n;
      tower_acc_d = tower_n;
      out_d       = '0;
      tower_out_d = '0;
      if (state_q == ST_ACCUM) begin
         if (tick) begin
            out_d       = acc_n;
            tower_out_d = tower_n;
            acc_d       = '0;
            tower_acc_d = '0;
            state_d     = ST_APPLY;
         end
      end else begin
         state_d = ST_ACCUM;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         tower_acc_q <= '0;
         out_q       <= '0;
         tower_out_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         tower_acc_q <= tower_acc_d;
         out_q       <= out_d;
         tower_out_q <= tower_out_d;
      end
   end

   assign in_ready      = (state_q == ST_ACCUM);
   assign applied_valid = (state_q == ST_APPLY);
   assign applied_dmg   = out_q;
   assign tower_dmg     = tower_out_q;

`ifdef DMG_STATS_EN
   logic [15:0] frame_q, frame_d;
   logic [7:0]  missed_q, missed_d;

   always_comb begin
      frame_d  = frame_q;
      missed_d = missed_q;
      if (state_q == ST_APPLY) begin
         frame_d = frame_q + 16'd1;
         if (tick && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         frame_q  <= '0;
         missed_q <= '0;
      end else begin
         frame_q  <= frame_d;
         missed_q <= missed_d;
      end
   end

   assign frame_count  = frame_q;
   assign missed_ticks = missed_q;
`else
   assign frame_count  = '0;
   assign missed_ticks = '0;
`endif

endmodule

// File: tb/tb_damage_accumulator.sv
// Scoreboard bench for damage_accumulator: directed frames, reset-in-APPLY, tick storms and random traffic.
module tb_damage_accumulator;

   localparam int NT    = 16;
   localparam int SEL_W = 5;
   localparam int IN_W  = 12;
   localparam int DMG_W = 8;

   typedef struct {
      logic [NT*DMG_W-1:0] bus;
      logic [DMG_W-1:0]    tower;
   } frame_t;

   logic                Clk = 1'b0;
   logic                Reset = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [SEL_W-1:0]    in_sel = '0;
   logic [IN_W-1:0]     in_dmg = '0;
   logic                tick = 1'b0;
   logic [NT*DMG_W-1:0] applied_dmg;
   logic [DMG_W-1:0]    tower_dmg;
   logic                applied_valid;
   logic [15:0]         frame_count;
   logic [7:0]          missed_ticks;

   damage_accumulator #(.NUM_TARGETS(NT), .SEL_W(SEL_W), .IN_W(IN_W), .DMG_W(DMG_W)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_dmg(in_dmg), .tick(tick), .applied_dmg(applied_dmg), .tower_dmg(tower_dmg),
      .applied_valid(applied_valid), .frame_count(frame_count), .missed_ticks(missed_ticks)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // reference model: per-frame sums in plain integers
   int     sum [NT];
   int     tower_sum;
   bit     m_apply;
   int     m_frames;
   int     m_missed;
   frame_t exp_q[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (sum[k]) sum[k] = 0;
      tower_sum = 0;
      m_apply   = 0;
      m_frames  = 0;
      m_missed  = 0;
      exp_q.delete();
   endtask

   task automatic step(input bit v, input int sel, input int dmg, input bit t, output bit acc);
      int     c;
      frame_t f;
      @(negedge Clk);
      in_valid = v;
      in_sel   = SEL_W'(sel);
      in_dmg   = IN_W'(dmg);
      tick     = t;
      acc      = v && !m_apply;
      if (m_apply) begin
         m_frames = (m_frames + 1) % 65536;
         if (t && m_missed < 255) m_missed++;
         m_apply = 0;
      end else begin
         if (acc) begin
            c = (dmg > 255) ? 255 : dmg;
            if (sel >= NT) tower_sum = (tower_sum + c > 255) ? 255 : tower_sum + c;
            else           sum[sel]  = (sum[sel] + c > 255) ? 255 : sum[sel] + c;
         end
         if (t) begin
            for (int k = 0; k < NT; k++) f.bus[k*DMG_W +: DMG_W] = DMG_W'(sum[k]);
            f.tower = DMG_W'(tower_sum);
            exp_q.push_back(f);
            foreach (sum[k]) sum[k] = 0;
            tower_sum = 0;
            m_apply   = 1;
         end
      end
   endtask

   task automatic idle();
      bit a;
      step(0, 0, 0, 0, a);
   endtask

   // monitor: compares DUT against the model state one tick after each rising edge
   initial begin
      frame_t f;
      forever begin
         @(posedge Clk);
         #1;
         if (!Reset) begin
            chk("in_ready", 128'(in_ready), 128'(!m_apply));
            chk("applied_valid", 128'(applied_valid), 128'(m_apply));
            if (applied_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 128'(1), 128'(0));
               end else begin
                  f = exp_q.pop_front();
                  chk("applied_dmg", 128'(applied_dmg), 128'(f.bus));
                  chk("tower_dmg", 128'(tower_dmg), 128'(f.tower));
               end
            end else begin
               chk("applied_dmg_idle", 128'(applied_dmg), 128'(0));
               chk("tower_dmg_idle", 128'(tower_dmg), 128'(0));
            end
`ifdef DMG_STATS_EN
            chk("frame_count", 128'(frame_count), 128'(16'(m_frames)));
            chk("missed_ticks", 128'(missed_ticks), 128'(8'(m_missed)));
`else
            chk("frame_count_tied", 128'(frame_count), 128'(0));
            chk("missed_ticks_tied", 128'(missed_ticks), 128'(0));
`endif
         end
      end
   end

   initial begin
      bit a;
      bit hv;
      int hs, hd;
      bit t;

      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_applied_valid", 128'(applied_valid), 128'(0));
      chk("rst_applied_dmg", 128'(applied_dmg), 128'(0));
      chk("rst_frame_count", 128'(frame_count), 128'(0));
      @(negedge Clk);
      Reset = 1'b0;

      // two hits on slot 3
      step(1, 3, 40, 0, a);
      step(1, 3, 50, 0, a);
      step(0, 0, 0, 1, a);
      idle();
      // clamp of oversize input, then saturating add
      step(1, 0, 'h300, 0, a);
      step(1, 0, 10, 0, a);
      step(0, 0, 0, 1, a);
      idle();
      // out-of-range selects go to the tower
      step(1, 16, 7, 0, a);
      step(1, 31, 8, 0, a);
      step(0, 0, 0, 1, a);
      idle();
      // request concurrent with tick lands in that frame, next frame empty
      step(1, 5, 20, 1, a);
      idle();
      step(0, 0, 0, 1, a);
      idle();
      // back-to-back ticks: the second is missed
      step(0, 0, 0, 1, a);
      step(0, 0, 0, 1, a);
      idle();

      // reset asserted in the APPLY cycle
      step(1, 2, 33, 1, a);
      @(posedge Clk);
      #3;
      Reset = 1'b1;
      in_valid = 1'b0;
      tick = 1'b0;
      model_reset();
      #1;
      chk("rst_apply_valid", 128'(applied_valid), 128'(0));
      chk("rst_apply_dmg", 128'(applied_dmg), 128'(0));
      chk("rst_apply_tower", 128'(tower_dmg), 128'(0));
      chk("rst_apply_ready", 128'(in_ready), 128'(1));
      @(negedge Clk);
      Reset = 1'b0;

      // continuous tick: drives missed_ticks to saturation
      for (int i = 0; i < 600; i++) step(0, 0, 0, 1, a);
      idle();

      // random traffic; a stalled request is held until accepted
      hv = 0; hs = 0; hd = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!hv && $urandom_range(0, 99) < 60) begin
            hv = 1;
            hs = int'($urandom_range(0, 31));
            hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 80));
         end
         t = ($urandom_range(0, 99) < 15);
         step(hv, hs, hd, t, a);
         if (a) hv = 0;
      end
      repeat (3) idle();
      @(posedge Clk);
      #2;
      chk("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
